// File: rtl/queen_stack_controller.sv
// queen_stack_controller
//   Sequences single push/pop requests from the 8-queen solver onto a
//   single-port synchronous stack RAM and reports completion/status.
// Ports:
//   clk, user_reset_n         : clock, asynchronous active-low reset
//   push, pop, push_data      : requests (sampled in IDLE only) and push entry
//   pop_data                  : registered popped entry
//   stack_ready               : one-cycle completion strobe per accepted request
//   underflow, overflow       : error strobes, coincident with stack_ready
//   empty, full, level        : stack occupancy
//   mem_addr, mem_wdata,
//   mem_we, mem_re, mem_rdata : stack RAM port (read data one cycle after mem_re)
module queen_stack_controller #(
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  user_reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  stack_ready,
  output logic                  underflow,
  output logic                  overflow,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   level,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WRITE     = 3'd1;
  localparam logic [2:0] S_READ      = 3'd2;
  localparam logic [2:0] S_READ_WAIT = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;
  localparam logic [2:0] S_ERROR     = 3'd5;

  localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH:0]   sp_q, sp_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
  logic                  err_ovf_q, err_ovf_d;   // 1: ERROR came from a push

  logic                  full_w, empty_w;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign full_w  = (sp_q == LVL_FULL);
  assign empty_w = (sp_q == '0);
  // Top of stack sits one below sp; only used in READ where sp > 0.
  assign rd_addr = sp_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    wdata_d    = wdata_q;
    pop_data_d = pop_data_q;
    err_ovf_d  = err_ovf_q;
    case (state_q)
      S_IDLE: begin
        // Push has priority; a simultaneous pop is silently dropped.
        if (push) begin
          if (full_w) begin
            state_d   = S_ERROR;
            err_ovf_d = 1'b1;
          end else begin
            state_d = S_WRITE;
            wdata_d = push_data;
          end
        end else if (pop) begin
          if (empty_w) begin
            state_d   = S_ERROR;
            err_ovf_d = 1'b0;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_WRITE: begin
        sp_d    = sp_q + 1'b1;
        state_d = S_DONE;
      end
      S_READ: begin
        sp_d    = sp_q - 1'b1;
        state_d = S_READ_WAIT;
      end
      S_READ_WAIT: begin
        pop_data_d = mem_rdata;
        state_d    = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q    <= S_IDLE;
      sp_q       <= '0;
      wdata_q    <= '0;
      pop_data_q <= '0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      wdata_q    <= wdata_d;
      pop_data_q <= pop_data_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  // Outputs are decoded from registered state only.
  assign stack_ready = (state_q == S_DONE) || (state_q == S_ERROR);
  assign underflow   = (state_q == S_ERROR) && !err_ovf_q;
  assign overflow    = (state_q == S_ERROR) &&  err_ovf_q;
  assign mem_we      = (state_q == S_WRITE);
  assign mem_re      = (state_q == S_READ);
  assign mem_wdata   = (state_q == S_WRITE) ? wdata_q : '0;

  always_comb begin
    mem_addr = '0;
    if (state_q == S_WRITE)     mem_addr = sp_q[ADDR_WIDTH-1:0];
    else if (state_q == S_READ) mem_addr = rd_addr;
  end

  assign pop_data = pop_data_q;
  assign level    = sp_q;
  assign empty    = empty_w;
  assign full     = full_w;

endmodule
